// File: rtl/param_stream_ctrl.sv
// Parameter ROM read scheduler: issues addresses to a fixed-latency ROM and
// buffers returned words in a small FIFO presented as a valid/ready stream.
module param_stream_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int OUT_DEPTH   = 24,
  parameter int REPEAT      = 1,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_ce,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready
);

  localparam int FIFO_DEPTH = ROM_LATENCY + 1;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int PASS_W     = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam int CRD_W      = $clog2(FIFO_DEPTH + ROM_LATENCY + 1) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]             state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [PASS_W-1:0]      pass;
  logic [ROM_LATENCY-1:0] vld_pipe;

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;

  logic [CRD_W-1:0]       inflight, used;
  logic                   issue, last_issue, push, pop, addr_wrap, drain_done;

  assign rom_ce         = 1'b1;
  assign rom_addr       = addr;
  assign busy           = (state == S_RUN) || (state == S_DRAIN);
  assign data_out_valid = (count != '0);
  assign data_out       = data_out_valid ? mem[rd_ptr] : '0;

  assign pop  = data_out_valid && data_out_ready && !abort;
  assign push = vld_pipe[ROM_LATENCY-1] && !abort;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < ROM_LATENCY; i++)
      inflight = inflight + CRD_W'(vld_pipe[i]);
  end

  // A word leaving the FIFO this cycle returns its credit immediately, which
  // is what sustains one issue per clock with only ROM_LATENCY+1 entries.
  assign used  = inflight + CRD_W'(count) - CRD_W'(pop);
  assign issue = (state == S_RUN) && (used < CRD_W'(FIFO_DEPTH));

  assign addr_wrap  = (addr == ADDR_WIDTH'(OUT_DEPTH - 1));
  assign last_issue = issue && addr_wrap && (pass == PASS_W'(REPEAT - 1));

  // Leave DRAIN in the cycle of the final transfer so done lands one cycle later.
  assign drain_done = (state == S_DRAIN) && (vld_pipe == '0) &&
                      ((count == '0) || ((count == CNT_W'(1)) && pop));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)      state_nxt = S_RUN;
      S_RUN:   if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_done) state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      addr     <= '0;
      pass     <= '0;
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (abort) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      addr     <= '0;
      pass     <= '0;
      vld_pipe <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      done     <= drain_done;
      vld_pipe <= (vld_pipe << 1) | ROM_LATENCY'(issue);
      if (issue) begin
        if (addr_wrap) begin
          addr <= '0;
          pass <= (pass == PASS_W'(REPEAT - 1)) ? '0 : pass + 1'b1;
        end else begin
          addr <= addr + 1'b1;
        end
      end
      if (push)
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset: data_out is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= rom_q;
  end

endmodule

// File: tb/tb_param_stream_ctrl.sv
// Randomized self-checking bench for param_stream_ctrl: a 4x2 instance for the
// timed scenarios and a 24x3 instance for random backpressure.
module tb_param_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_start, s_abort, s_ready, s_busy, s_done, s_ce, s_valid;
  logic [2:0]  s_addr;
  logic [31:0] s_q, s_dout;
  logic        b_start, b_abort, b_ready, b_busy, b_done, b_ce, b_valid;
  logic [5:0]  b_addr;
  logic [31:0] b_q, b_dout;

  int n_chk  = 0;
  int n_fail = 0;

  param_stream_ctrl #(.DATA_WIDTH(32), .OUT_DEPTH(4), .REPEAT(2), .ROM_LATENCY(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .busy(s_busy), .done(s_done),
    .rom_addr(s_addr), .rom_ce(s_ce), .rom_q(s_q), .data_out(s_dout),
    .data_out_valid(s_valid), .data_out_ready(s_ready));

  param_stream_ctrl #(.DATA_WIDTH(32), .OUT_DEPTH(24), .REPEAT(3), .ROM_LATENCY(2)) u_big (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort), .busy(b_busy), .done(b_done),
    .rom_addr(b_addr), .rom_ce(b_ce), .rom_q(b_q), .data_out(b_dout),
    .data_out_valid(b_valid), .data_out_ready(b_ready));

  // Behavioural ROMs: word i = 0x10+i, two-cycle read latency.
  logic [2:0] s_a1;
  logic [5:0] b_a1;
  always @(posedge clk) begin
    s_a1 <= s_addr;
    s_q  <= 32'h10 + 32'(s_a1);
    b_a1 <= b_addr;
    b_q  <= 32'h10 + 32'(b_a1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0 with ready held; check the fixed cycle-accurate profile.
  task automatic free_run(input bit hold);
    s_start = 1'b1;
    s_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk("fr_valid", s_valid, (k >= 4 && k <= 11));
      if (k >= 4 && k <= 11) chk("fr_data", s_dout, 32'h10 + (k - 4) % 4);
      chk("fr_addr", s_addr, (k >= 1 && k <= 8) ? (k - 1) % 4 : 0);
      chk("fr_busy", s_busy, (k >= 1 && k <= 11) || (hold && k == 13));
      chk("fr_done", s_done, k == 12);
      next_cyc();
      if (!hold) s_start = 1'b0;
    end
    s_start = 1'b0;
  endtask

  // Scoreboard: expected stream is 0x10 + (n mod depth) for n < depth*repeat.
  task automatic drain_stream(input bit big, input int pct, input int max_cyc);
    int depth, total, idx, ndone;
    logic v, r, dn, pv, pr;
    logic [31:0] d, pd;
    depth = big ? 24 : 4;
    total = big ? 72 : 8;
    idx = 0; ndone = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    for (int c = 0; c < max_cyc; c++) begin
      r = ($urandom_range(0, 99) < pct);
      if (big) b_ready = r; else s_ready = r;
      @(negedge clk);
      v  = big ? b_valid : s_valid;
      d  = big ? b_dout  : s_dout;
      dn = big ? b_done  : s_done;
      if (pv && !pr) begin
        chk("hold_valid", v, 1'b1);
        chk("hold_data", d, pd);
      end
      if (v && r) begin
        chk("word", d, 32'h10 + (idx % depth));
        idx++;
      end
      if (dn) ndone++;
      pv = v; pr = r; pd = d;
      next_cyc();
      if (dn) break;
    end
    chk("word_count", idx, total);
    chk("done_count", ndone, 1);
    @(negedge clk);
    chk("done_pulse", big ? b_done : s_done, 1'b0);
    chk("busy_after", big ? b_busy : s_busy, 1'b0);
    next_cyc();
    s_ready = 1'b0;
    b_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    s_start = 1'b0; s_abort = 1'b0; s_ready = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
    repeat (2) next_cyc();
    @(negedge clk);
    chk("rst_busy", s_busy, 1'b0);
    chk("rst_done", s_done, 1'b0);
    chk("rst_addr", s_addr, 0);
    chk("rst_ce", s_ce, 1'b1);
    chk("rst_valid", s_valid, 1'b0);
    chk("rst_dout", s_dout, 0);
    chk("rst_big_busy", b_busy, 1'b0);
    next_cyc();
    rst = 1'b1;
    repeat (2) next_cyc();

    free_run(1'b0);
    repeat (2) next_cyc();

    // Backpressure: consumer stalled for cycles 0..9.
    s_start = 1'b1;
    s_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 9) begin
        chk("bp_addr", s_addr, 3);
        chk("bp_valid", s_valid, 1'b1);
        chk("bp_head", s_dout, 32'h10);
      end
      next_cyc();
      s_start = 1'b0;
    end
    drain_stream(1'b0, 100, 100);
    repeat (2) next_cyc();

    // Abort in cycle 6, restart in cycle 10, first word held at cycle 14.
    for (int k = 0; k < 15; k++) begin
      s_start = (k == 0 || k == 10);
      s_abort = (k == 6);
      s_ready = (k != 14);
      @(negedge clk);
      if (k >= 4 && k <= 6) chk("ab_valid_pre", s_valid, 1'b1);
      if (k >= 7 && k <= 13) chk("ab_valid_post", s_valid, 1'b0);
      if (k >= 7 && k <= 10) chk("ab_busy", s_busy, 1'b0);
      chk("ab_done", s_done, 1'b0);
      if (k == 14) begin
        chk("ab_first_valid", s_valid, 1'b1);
        chk("ab_first_data", s_dout, 32'h10);
      end
      next_cyc();
    end
    s_start = 1'b0;
    s_abort = 1'b0;
    drain_stream(1'b0, 100, 100);
    repeat (2) next_cyc();

    // Asynchronous reset in DRAIN (cycle 10), between clock edges.
    s_start = 1'b1;
    s_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      next_cyc();
      s_start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", s_busy, 1'b0);
    chk("ar_valid", s_valid, 1'b0);
    chk("ar_addr", s_addr, 0);
    chk("ar_dout", s_dout, 0);
    chk("ar_done", s_done, 1'b0);
    s_start = 1'b1;
    repeat (2) next_cyc();
    chk("ar_start_ignored", s_busy, 1'b0);
    s_start = 1'b0;
    rst = 1'b1;
    repeat (2) next_cyc();
    free_run(1'b0);
    repeat (2) next_cyc();

    // Held start: second stream begins in the cycle after done.
    free_run(1'b1);
    drain_stream(1'b0, 100, 100);
    repeat (2) next_cyc();

    // start together with abort in IDLE: nothing begins.
    s_start = 1'b1;
    s_abort = 1'b1;
    next_cyc();
    s_start = 1'b0;
    s_abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("sa_busy", s_busy, 1'b0);
      chk("sa_addr", s_addr, 0);
      chk("sa_valid", s_valid, 1'b0);
      next_cyc();
    end

    // Random 50% ready on the 24x3 instance.
    b_start = 1'b1;
    next_cyc();
    b_start = 1'b0;
    drain_stream(1'b1, 50, 3000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
